// File: rtl/rectangle80_key_sched.sv
// RECTANGLE-80 key schedule: loads an 80-bit key and issues round keys 0..25 one per accepted handshake.
// Key 0 is valid the cycle after the load; outputs hold while i_rkey_ready is low.
module rectangle80_key_sched (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_load,
    input  logic [79:0] iv_key,
    output logic        o_key_ready,
    input  logic        i_abort,
    output logic [63:0] ov_rkey,
    output logic [4:0]  ov_rkey_idx,
    output logic        o_rkey_valid,
    input  logic        i_rkey_ready,
    output logic        o_done
);
    localparam logic [4:0] LAST_IDX = 5'd25;
    localparam logic [4:0] RC_INIT  = 5'h01;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t      state;
    logic [15:0] row0, row1, row2, row3, row4;
    logic [4:0]  rc;
    logic [4:0]  idx;
    logic        key_ready_q;
    logic        rkey_valid_q;
    logic        done_q;

    logic [15:0] s0, s1, s2, s3;
    logic [15:0] nxt0, nxt1, nxt2, nxt3, nxt4;
    logic [4:0]  rc_nxt;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h6;
            4'h1: y = 4'h5;
            4'h2: y = 4'hC;
            4'h3: y = 4'hA;
            4'h4: y = 4'h1;
            4'h5: y = 4'hE;
            4'h6: y = 4'h7;
            4'h7: y = 4'h9;
            4'h8: y = 4'hB;
            4'h9: y = 4'h0;
            4'hA: y = 4'h3;
            4'hB: y = 4'hD;
            4'hC: y = 4'h8;
            4'hD: y = 4'hF;
            4'hE: y = 4'h4;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Only the four low columns pass through the S-box; row0 carries the nibble LSB.
    always_comb begin
        logic [3:0] nib;
        nib = 4'h0;
        s0  = row0;
        s1  = row1;
        s2  = row2;
        s3  = row3;
        for (int j = 0; j < 4; j++) begin
            nib   = sbox({row3[j], row2[j], row1[j], row0[j]});
            s0[j] = nib[0];
            s1[j] = nib[1];
            s2[j] = nib[2];
            s3[j] = nib[3];
        end
        nxt0   = ({s0[7:0], s0[15:8]} ^ s1) ^ {11'd0, rc};
        nxt1   = s2;
        nxt2   = s3;
        nxt3   = {s3[3:0], s3[15:4]} ^ row4;
        nxt4   = s0;
        rc_nxt = {rc[3:0], rc[4] ^ rc[2]};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            row0         <= '0;
            row1         <= '0;
            row2         <= '0;
            row3         <= '0;
            row4         <= '0;
            rc           <= RC_INIT;
            idx          <= '0;
            key_ready_q  <= 1'b1;
            rkey_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_key_load) begin
                        row4         <= iv_key[79:64];
                        row3         <= iv_key[63:48];
                        row2         <= iv_key[47:32];
                        row1         <= iv_key[31:16];
                        row0         <= iv_key[15:0];
                        idx          <= '0;
                        rc           <= RC_INIT;
                        state        <= S_ISSUE;
                        key_ready_q  <= 1'b0;
                        rkey_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    done_q <= 1'b0;
                    // Abort wins over a same-cycle transfer and suppresses the update.
                    if (i_abort) begin
                        state        <= S_IDLE;
                        key_ready_q  <= 1'b1;
                        rkey_valid_q <= 1'b0;
                    end else if (i_rkey_ready) begin
                        if (idx == LAST_IDX) begin
                            state        <= S_IDLE;
                            key_ready_q  <= 1'b1;
                            rkey_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            row0 <= nxt0;
                            row1 <= nxt1;
                            row2 <= nxt2;
                            row3 <= nxt3;
                            row4 <= nxt4;
                            rc   <= rc_nxt;
                            idx  <= idx + 5'd1;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    key_ready_q  <= 1'b1;
                    rkey_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign ov_rkey      = {row3, row2, row1, row0};
    assign ov_rkey_idx  = idx;
    assign o_key_ready  = key_ready_q;
    assign o_rkey_valid = rkey_valid_q;
    assign o_done       = done_q;

endmodule

// File: doc/rectangle80_key_sched.md
# rectangle80_key_sched

Sequential key-schedule controller for the round-based RECTANGLE-80 core. It loads an 80-bit master key into five 16-bit key rows and generates round keys 0..25 in order, one per accepted handshake. Each advance applies the S-box layer, the row Feistel shift and the round constant. It sits between the key-input interface and the round datapath, which consumes one 64-bit round key per round.

## Interface
- No parameters. Round count is fixed at 25, giving 26 round keys.
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_key_load  in  1  load request; sampled only in IDLE
- iv_key  in  80  master key; row4=[79:64], row3=[63:48], row2=[47:32], row1=[31:16], row0=[15:0]
- o_key_ready  out  1  high in IDLE only
- i_abort  in  1  synchronous abort of the current schedule
- ov_rkey  out  64  current round key {row3,row2,row1,row0}
- ov_rkey_idx  out  5  index of ov_rkey, 0..25
- o_rkey_valid  out  1  ov_rkey and ov_rkey_idx are valid
- i_rkey_ready  in  1  consumer accepts the round key
- o_done  out  1  one-cycle pulse after key 25 is accepted

## Operation
- Clock and reset are fixed: one clock (i_clk); reset i_rst_n is asynchronous, active-low.
- FSM states: IDLE and ISSUE.
- IDLE:
  - o_key_ready=1, o_rkey_valid=0.
  - On i_key_load=1, load rows from iv_key, set idx=0 and rc=5'h01, then go to ISSUE.
- ISSUE:
  - o_rkey_valid=1.
  - A transfer occurs when o_rkey_valid & i_rkey_ready.
  - On a transfer with idx<25, apply one update and idx+=1.
  - On a transfer with idx==25, go to IDLE and pulse o_done.
  - i_key_load is ignored in ISSUE.
- Update, in this order:
  - S-box on columns j=0..3. Nibble {row3[j],row2[j],row1[j],row0[j]} (row0 is the LSB) maps via S = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2. Columns 4..15 and row4 are untouched.
  - Feistel on the post-S-box rows:
    - row0' = rotl(row0,8) ^ row1
    - row1' = row2
    - row2' = row3
    - row3' = rotl(row3,12) ^ row4
    - row4' = row0
  - row0'[4:0] ^= rc.
- Round constant: 5-bit LFSR, rc ← {rc[3:0], rc[4]^rc[2]}, stepped on every update. RC[0..5] = 01,02,04,09,12,05.
- Abort:
  - i_abort=1 in ISSUE goes to IDLE next cycle with no o_done pulse.
  - Abort has priority over a simultaneous transfer: that key counts as consumed, and no update occurs.
  - i_abort in IDLE has no effect.
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.

## Timing
- Reset values:
  - State IDLE; all rows 0; rc=5'h01; idx=0.
  - o_key_ready=1; o_rkey_valid=0; o_done=0; ov_rkey=0; ov_rkey_idx=0.
- Load latency: i_key_load sampled high at edge N gives o_rkey_valid=1 with key 0 from edge N on.
- Throughput: with i_rkey_ready held high, one key per cycle. Keys 0..25 occupy 26 consecutive cycles.
- o_done pulses in the cycle after key 25 transfers. o_key_ready=1 in that same cycle, so a new load is accepted immediately.
- Backpressure: while i_rkey_ready=0, ov_rkey, ov_rkey_idx and o_rkey_valid hold stable.
- Reset mid-schedule returns to the reset values immediately (asynchronous assertion). Release is synchronous to i_clk at the module boundary.
- idx never exceeds 25. rc is 5 bits and is never zero after load.

## Test plan
- All-zero key, ready held high:
  - Key 0 = 64'h0; key 1 = 64'h0000_0000_000F_000E.
  - o_done pulses exactly 26 cycles after the first valid.
  - ov_rkey_idx runs 0..25.
- Random keys versus a software RECTANGLE-80 reference model: all 26 round keys match, and rc follows 01,02,04,09,12,05,...
- Random i_rkey_ready backpressure: outputs stay stable while stalled, no key is skipped or duplicated, and key order is identical to the no-stall run.
- i_abort asserted at idx=7 together with i_rkey_ready=1:
  - Next cycle is IDLE with o_key_ready=1.
  - No o_done pulse.
  - A following load restarts at idx=0 with rc=01.
- i_key_load pulsed during ISSUE is ignored, and the key sequence is unchanged. A load in the o_done cycle is accepted and key 0 appears on the next cycle.
- i_rst_n asserted at idx=12: all outputs take reset values asynchronously, before the next edge.
